// File: rtl/reg_bus_pkg.sv
// reg_bus_pkg: shared types and register-index constants for the register-bus controller.
// Rev 1.0
`default_nettype none

package reg_bus_pkg;

  typedef enum logic [1:0] {
    OP_MOV      = 2'b00,
    OP_LOAD_IMM = 2'b01,
    OP_READ     = 2'b10,
    OP_RSVD     = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  // 8080 register encoding; index 6 is the memory operand M
  localparam logic [2:0] REG_B = 3'd0;
  localparam logic [2:0] REG_C = 3'd1;
  localparam logic [2:0] REG_D = 3'd2;
  localparam logic [2:0] REG_E = 3'd3;
  localparam logic [2:0] REG_H = 3'd4;
  localparam logic [2:0] REG_L = 3'd5;
  localparam logic [2:0] REG_M = 3'd6;
  localparam logic [2:0] REG_A = 3'd7;

endpackage

`default_nettype wire

// File: rtl/reg_bus_onehot.sv
// reg_bus_onehot: 3-bit index to one-hot register strobe decoder; the M slot never decodes.
// Rev 1.0
`default_nettype none

module reg_bus_onehot
  import reg_bus_pkg::*;
#(
  parameter int NUM_REGS = 8
) (
  input  logic                en_i,
  input  logic [2:0]          idx_i,
  output logic [NUM_REGS-1:0] onehot_o
);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
    if (i == int'(REG_M)) begin : g_mem
      assign onehot_o[i] = 1'b0;
    end else begin : g_reg
      assign onehot_o[i] = en_i && (int'(idx_i) == i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_bus_ctrl.sv
// reg_bus_ctrl: sequences one MOV / LOAD_IMM / READ transfer on the shared 8-bit register bus.
// Rev 1.0
`default_nettype none

module reg_bus_ctrl
  import reg_bus_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk50M_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic [1:0]          op_i,
  input  logic [2:0]          src_i,
  input  logic [2:0]          dst_i,
  input  logic [7:0]          imm_i,
  input  logic [7:0]          bus_i,
  output logic [7:0]          bus_drv_o,
  output logic                bus_oe_o,
  output logic [NUM_REGS-1:0] reg_rd_o,
  output logic [NUM_REGS-1:0] reg_wr_o,
  output logic                mem_rd_o,
  output logic                mem_wr_o,
  input  logic                mem_rdy_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [7:0]          data_o
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  op_t        op_q, op_d;
  logic [2:0] src_q, src_d, dst_q, dst_d;
  logic [7:0] tmp_q, tmp_d, data_q, data_d, cnt_q, cnt_d;
  logic [7:0] cnt_inc;
  logic       src_mem, dst_mem, req_reject;

  assign src_mem    = (src_q == REG_M);
  assign dst_mem    = (dst_q == REG_M);
  assign cnt_inc    = cnt_q + 8'd1;
  assign req_reject = (op_t'(op_i) == OP_RSVD) ||
                      (op_t'(op_i) == OP_MOV && src_i == REG_M && dst_i == REG_M);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    tmp_d   = tmp_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          op_d  = op_t'(op_i);
          src_d = src_i;
          dst_d = dst_i;
          cnt_d = 8'd0;
          if (req_reject) begin
            state_d = ERR;
          end else if (op_t'(op_i) == OP_LOAD_IMM) begin
            tmp_d   = imm_i;
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (!src_mem || mem_rdy_i) begin
          tmp_d = bus_i;
          cnt_d = 8'd0;
          if (op_q == OP_READ) begin
            data_d  = bus_i;
            state_d = DONE;
          end else begin
            state_d = WR;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_CNT) state_d = ERR;
        end
      end
      WR: begin
        if (!dst_mem || mem_rdy_i) begin
          if (op_q == OP_MOV) data_d = tmp_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_CNT) state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk50M_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= OP_MOV;
      src_q   <= 3'd0;
      dst_q   <= 3'd0;
      tmp_q   <= 8'h00;
      data_q  <= 8'h00;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      tmp_q   <= tmp_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Every strobe is a pure decode of the state flops, so the bus has a single driver per state
  reg_bus_onehot #(.NUM_REGS(NUM_REGS)) u_rd_dec (
    .en_i     (state_q == RD && !src_mem),
    .idx_i    (src_q),
    .onehot_o (reg_rd_o)
  );

  reg_bus_onehot #(.NUM_REGS(NUM_REGS)) u_wr_dec (
    .en_i     (state_q == WR && !dst_mem),
    .idx_i    (dst_q),
    .onehot_o (reg_wr_o)
  );

  assign mem_rd_o  = (state_q == RD) && src_mem;
  assign mem_wr_o  = (state_q == WR) && dst_mem;
  assign bus_oe_o  = (state_q == WR);
  assign bus_drv_o = (state_q == WR) ? tmp_q : 8'h00;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign err_o     = (state_q == ERR);
  assign data_o    = data_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_bus_ctrl.sv
// tb_reg_bus_ctrl: scoreboard bench with a register-file/memory responder and a transfer-level model.
// Rev 1.0
`default_nettype none

module tb_reg_bus_ctrl;
  import reg_bus_pkg::*;

  localparam int NUM_REGS    = 8;
  localparam int MEM_TIMEOUT = 15;

  logic                clk50M_i = 1'b0;
  logic                rst_ni   = 1'b0;
  logic                req_i    = 1'b0;
  logic [1:0]          op_i     = 2'b00;
  logic [2:0]          src_i    = 3'd0;
  logic [2:0]          dst_i    = 3'd0;
  logic [7:0]          imm_i    = 8'h00;
  logic [7:0]          bus_i;
  logic [7:0]          bus_drv_o;
  logic                bus_oe_o;
  logic [NUM_REGS-1:0] reg_rd_o;
  logic [NUM_REGS-1:0] reg_wr_o;
  logic                mem_rd_o;
  logic                mem_wr_o;
  logic                mem_rdy_i;
  logic                busy_o;
  logic                done_o;
  logic                err_o;
  logic [7:0]          data_o;

  reg_bus_ctrl #(.NUM_REGS(NUM_REGS), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk50M_i (clk50M_i),
    .rst_ni   (rst_ni),
    .req_i    (req_i),
    .op_i     (op_i),
    .src_i    (src_i),
    .dst_i    (dst_i),
    .imm_i    (imm_i),
    .bus_i    (bus_i),
    .bus_drv_o(bus_drv_o),
    .bus_oe_o (bus_oe_o),
    .reg_rd_o (reg_rd_o),
    .reg_wr_o (reg_wr_o),
    .mem_rd_o (mem_rd_o),
    .mem_wr_o (mem_wr_o),
    .mem_rdy_i(mem_rdy_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o),
    .data_o   (data_o)
  );

  always #10 clk50M_i = ~clk50M_i;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] rf_dut[8];
  logic [7:0] rf_ref[8];
  logic [7:0] data_ref = 8'h00;
  int         mem_delay = 0;
  int         wcnt = 0;

  // Register file / memory cell as seen from the bus; slot 6 is the memory operand
  always_comb begin
    bus_i = 8'h00;
    if (bus_oe_o) bus_i = bus_drv_o;
    else if (mem_rd_o) bus_i = rf_dut[6];
    else for (int i = 0; i < 8; i++) if (reg_rd_o[i]) bus_i = rf_dut[i];
  end

  always_comb mem_rdy_i = (mem_rd_o || mem_wr_o) && (wcnt == mem_delay);

  always @(posedge clk50M_i) begin
    if (mem_rd_o || mem_wr_o) wcnt <= wcnt + 1;
    else wcnt <= 0;
    for (int i = 0; i < 8; i++) if (reg_wr_o[i]) rf_dut[i] <= bus_i;
    if (mem_wr_o && mem_rdy_i) rf_dut[6] <= bus_i;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer-level reference: what one request does to registers, memory and data_o
  task automatic model_push(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d,
                            input logic [7:0] imm, input int dly);
    exp_t       e;
    logic [7:0] v;
    bit         uses_mem;
    e.is_err = 1'b1;
    if (!(op == 2'b11 || (op == 2'b00 && s == 3'd6 && d == 3'd6))) begin
      uses_mem = ((op != 2'b01) && s == 3'd6) || ((op != 2'b10) && d == 3'd6);
      if (!(uses_mem && dly >= MEM_TIMEOUT)) begin
        v = (op == 2'b01) ? imm : rf_ref[s];
        if (op != 2'b10) rf_ref[d] = v;
        if (op != 2'b01) data_ref = v;
        e.is_err = 1'b0;
      end
    end
    e.data = data_ref;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 200) begin
      @(negedge clk50M_i);
      n++;
    end
    if (busy_o) begin
      checks++;
      errors++;
      $display("FAIL idle_wait: busy_o still 1 after %0d cycles", n);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after acceptance
  task automatic issue(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d,
                       input logic [7:0] imm, input int dly, input bit track);
    wait_idle();
    op_i      = op;
    src_i     = s;
    dst_i     = d;
    imm_i     = imm;
    mem_delay = dly;
    req_i     = 1'b1;
    if (track) model_push(op, s, d, imm, dly);
    @(posedge clk50M_i);
    @(negedge clk50M_i);
    req_i = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(done_o || err_o) && n < 100) begin
      @(negedge clk50M_i);
      n++;
    end
    if (!(done_o || err_o)) begin
      checks++;
      errors++;
      $display("FAIL done_wait: no done_o/err_o within %0d cycles", n);
    end
  endtask

  // Scoreboard monitor and bus-ownership invariants
  always @(negedge clk50M_i) begin
    exp_t e;
    logic viol;
    if (rst_ni) begin
      if (done_o || err_o) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: done=%0b err=%0b with no pending request", done_o, err_o);
        end else begin
          e = sb_q.pop_front();
          check("sb_kind_err", 32'(err_o), 32'(e.is_err));
          check("sb_kind_done", 32'(done_o), 32'(!e.is_err));
          check("sb_data", 32'(data_o), 32'(e.data));
        end
      end
      viol = (bus_oe_o && ((|reg_rd_o) || mem_rd_o)) || ($countones(reg_rd_o) > 1) ||
             ($countones(reg_wr_o) > 1) || ((|reg_rd_o) && (|reg_wr_o)) ||
             reg_rd_o[6] || reg_wr_o[6] || (mem_rd_o && mem_wr_o);
      check("bus_excl", 32'(viol), 32'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r;
    int dly;
    for (int i = 0; i < 8; i++) rf_ref[i] = 8'h00;

    repeat (2) @(negedge clk50M_i);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_strobes", {16'(reg_rd_o), 8'(reg_wr_o), 6'd0, mem_rd_o, mem_wr_o}, 32'd0);
    check("rst_oe_drv", {23'd0, bus_oe_o, bus_drv_o}, 32'd0);
    check("rst_done_err", {30'd0, done_o, err_o}, 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk50M_i);

    for (int i = 0; i < 8; i++) begin
      issue(2'b01, 3'd0, 3'(i), 8'($urandom), 0, 1'b1);
      wait_done();
    end

    // LOAD_IMM A <- 0xA5
    issue(2'b01, 3'd0, 3'd7, 8'hA5, 0, 1'b1);
    check("li_wr", 32'(reg_wr_o), 32'h80);
    check("li_drv", 32'(bus_drv_o), 32'hA5);
    check("li_oe", 32'(bus_oe_o), 32'd1);
    @(negedge clk50M_i);
    check("li_done", 32'(done_o), 32'd1);
    check("li_reg_a", 32'(rf_dut[7]), 32'hA5);

    // MOV B <- A
    issue(2'b00, 3'd7, 3'd0, 8'h00, 0, 1'b1);
    check("mov_rd", 32'(reg_rd_o), 32'h80);
    check("mov_rd_oe", 32'(bus_oe_o), 32'd0);
    @(negedge clk50M_i);
    check("mov_wr", 32'(reg_wr_o), 32'h01);
    check("mov_drv", 32'(bus_drv_o), 32'hA5);
    @(negedge clk50M_i);
    check("mov_done", 32'(done_o), 32'd1);
    check("mov_data", 32'(data_o), 32'hA5);

    // READ M with three wait cycles
    @(negedge clk50M_i);
    issue(2'b01, 3'd0, 3'd6, 8'h3C, 0, 1'b1);
    wait_done();
    issue(2'b10, 3'd6, 3'd0, 8'h00, 3, 1'b1);
    n = 0;
    while (mem_rd_o && n < 50) begin
      n++;
      @(negedge clk50M_i);
    end
    check("rdm_len", 32'(n), 32'd4);
    check("rdm_done", 32'(done_o), 32'd1);
    check("rdm_data", 32'(data_o), 32'h3C);

    // MOV M <- C, memory never ready
    @(negedge clk50M_i);
    issue(2'b00, 3'd1, 3'd6, 8'h00, 255, 1'b1);
    @(negedge clk50M_i);
    n = 0;
    while (mem_wr_o && n < 50) begin
      n++;
      @(negedge clk50M_i);
    end
    check("to_len", 32'(n), 32'd15);
    check("to_err", 32'(err_o), 32'd1);
    @(negedge clk50M_i);
    check("to_busy", 32'(busy_o), 32'd0);
    check("to_data", 32'(data_o), 32'h3C);

    // Rejected requests
    issue(2'b00, 3'd6, 3'd6, 8'h00, 0, 1'b1);
    check("rej_mm_err", 32'(err_o), 32'd1);
    check("rej_mm_strb", {16'(reg_rd_o), 8'(reg_wr_o), 6'd0, mem_rd_o, mem_wr_o}, 32'd0);
    @(negedge clk50M_i);
    issue(2'b11, 3'd2, 3'd3, 8'h00, 0, 1'b1);
    check("rej_op_err", 32'(err_o), 32'd1);
    check("rej_op_strb", {16'(reg_rd_o), 8'(reg_wr_o), 6'd0, mem_rd_o, mem_wr_o}, 32'd0);
    @(negedge clk50M_i);

    // Reset in the WR cycle of MOV E <- D: no write lands, data_o clears
    issue(2'b00, 3'd2, 3'd3, 8'h00, 0, 1'b0);
    @(negedge clk50M_i);
    check("arst_pre_wr", 32'(reg_wr_o), 32'h08);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_wr", 32'(reg_wr_o), 32'd0);
    check("arst_oe", 32'(bus_oe_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    data_ref = 8'h00;
    @(negedge clk50M_i);
    rst_ni = 1'b1;
    @(negedge clk50M_i);
    check("arst_reg_e", 32'(rf_dut[3]), 32'(rf_ref[3]));

    // A request held during busy_o is not taken
    issue(2'b00, 3'd3, 3'd1, 8'h00, 0, 1'b1);
    op_i  = 2'b01;
    dst_i = 3'd4;
    imm_i = 8'h77;
    req_i = 1'b1;
    @(negedge clk50M_i);
    @(negedge clk50M_i);
    req_i = 1'b0;
    repeat (3) @(negedge clk50M_i);
    check("busy_ign_idle", 32'(busy_o), 32'd0);

    // Randomized transfers
    repeat (300) begin
      r = int'($urandom_range(0, 15));
      case (int'($urandom_range(0, 9)))
        7:       dly = 14;
        8:       dly = 15;
        9:       dly = int'($urandom_range(16, 30));
        default: dly = int'($urandom_range(0, 4));
      endcase
      issue((r < 6) ? 2'b00 : (r < 10) ? 2'b10 : (r < 14) ? 2'b01 : 2'b11,
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom), dly, 1'b1);
      wait_done();
    end

    repeat (3) @(negedge clk50M_i);
    for (int i = 0; i < 8; i++) check($sformatf("final_reg%0d", i), 32'(rf_dut[i]), 32'(rf_ref[i]));
    check("final_sb_empty", 32'(sb_q.size()), 32'd0);
    check("final_data", 32'(data_o), 32'(data_ref));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
